ram_dp_sync: RTL and testbench
==============================

Name: ram_dp_sync

Overview:
- Synchronous, parametrised successor to the processor's unified instruction/data RAM.
- Two ports:
  - a read-only fetch port for instruction fetch;
  - a read/write data port for LDR/STR, with byte enables and a req/ready handshake.
- Zero-fills its contents after reset with an internal clear sequencer.
- Reports data-port accesses beyond DEPTH as errors.

Parameters:
- DATA_SIZE, 32, word width in bits; must be a multiple of 8.
- ADDRESS_SIZE, 16, word-address width.
- DEPTH, 65536, implemented words; must satisfy 1 <= DEPTH <= 2^ADDRESS_SIZE.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_req  input  1  data-port request.
- data_we  input  1  1 = write (STR), 0 = read (LDR).
- data_be  input  DATA_SIZE/8  byte write enables; ignored for reads.
- data_addr  input  ADDRESS_SIZE  data word address.
- data_wdata  input  DATA_SIZE  write data.
- data_ready  output  1  port can accept a request this cycle.
- data_rvalid  output  1  read data valid, one-cycle pulse.
- data_rdata  output  DATA_SIZE  read data.
- data_err  output  1  one-cycle pulse: accepted access with data_addr >= DEPTH.
- fetch_req  input  1  fetch request.
- fetch_addr  input  ADDRESS_SIZE  fetch word address.
- fetch_rvalid  output  1  fetch data valid, one-cycle pulse.
- fetch_rdata  output  DATA_SIZE  instruction word.
- init_done  output  1  clear sequence complete.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - data_ready, data_rvalid, data_err, fetch_rvalid and init_done = 0.
  - data_rdata and fetch_rdata = 0.
  - FSM = CLEAR; clear counter = 0.
- FSM states:
  - CLEAR: writes 0 to mem[counter] each cycle and increments the counter. When counter == DEPTH-1 and the final write is done, transitions to READY.
  - READY: init_done = 1 and data_ready = 1. Stays in READY until reset.
- CLEAR takes exactly DEPTH cycles after rst_n deasserts.
- While in CLEAR:
  - data_ready = 0;
  - data_req and fetch_req are ignored (no rvalid, no err);
  - requesters must hold or retry.
- Data accept: a request is accepted on a rising edge with data_req & data_ready.
- Data write (data_we = 1):
  - for each i with data_be[i] = 1, byte i of mem[data_addr] is updated at that edge;
  - no rvalid is produced;
  - data_be = 0 is a legal no-op.
- Data read (data_we = 0):
  - data_rdata is registered;
  - data_rvalid = 1 in the cycle after acceptance;
  - data_rdata holds its value until the next read completes.
- Out-of-range (data_addr >= DEPTH):
  - no memory update;
  - data_err pulses in the cycle after acceptance;
  - a read also pulses data_rvalid with data_rdata = 0.
- Fetch:
  - accepted in READY on any edge with fetch_req = 1;
  - fetch_rvalid pulses in the next cycle with fetch_rdata = mem[fetch_addr];
  - fetch_rdata is held otherwise.
  - An address >= DEPTH returns 0; there is no error output on the fetch port.
- Throughput: back-to-back requests are accepted every cycle on both ports, independently.
- Collision (data write and fetch to the same address in the same cycle): read-first, so the fetch returns the old word. A data read issued in the next cycle returns the new word.
- Reset mid-operation:
  - any in-flight rvalid/err is dropped;
  - the FSM returns to CLEAR and the entire memory is re-zeroed.
- There is no tri-state output: data_rdata is never Z.

Decomposition:
- Shared package ram_pkg holds:
  - FSM state encoding ST_CLEAR / ST_READY;
  - the byte-lane width constant BYTE_W = 8.
- One natural sub-module, ram_bytelane_merge: combinational merge of data_be / data_wdata into the old word. Keeps the storage array and FSM in the top.

Test Plan (bench overrides DEPTH = 16, other parameters at default):
- Reset release then idle:
  - init_done rises exactly 16 cycles after rst_n goes high, and data_ready rises with it.
  - A fetch of every address 0..15 then returns 0x00000000.
- Write 0xDEADBEEF to address 5 with data_be = 4'b1111, then read address 5:
  - data_rvalid pulses 1 cycle after the read is accepted;
  - data_rdata = 0xDEADBEEF.
- Write 0x000000AA to address 5 with data_be = 4'b0001, then read: data_rdata = 0xDEADBEAA.
- Same cycle, data write 0x12345678 to address 3 and fetch of address 3:
  - fetch_rdata = old value 0x00000000;
  - a fetch of address 3 one cycle later returns 0x12345678.
- Out-of-range: read data_addr = 16 -> data_err and data_rvalid pulse together, data_rdata = 0. Write to address 20 -> data_err pulses, and no address 0..15 changes.
- Reset mid-operation: assert rst_n low during a read.
  - All outputs are 0 immediately (asynchronous reset).
  - After release, init_done stays low for 16 cycles.
  - A read of address 5 then returns 0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants for the synchronous dual-port RAM: controller state encoding
// and the byte-lane width used by the byte-enable merge.
package ram_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage : ram_pkg

// File: rtl/ram_bytelane_merge.sv
// Combinational byte-lane merge: lanes with their enable set take the new write
// data, all others keep the currently stored word.
module ram_bytelane_merge
    import ram_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0]        old_i,
    input  logic [DATA_SIZE-1:0]        wdata_i,
    input  logic [DATA_SIZE/BYTE_W-1:0] be_i,
    output logic [DATA_SIZE-1:0]        merged_o
);

    localparam int unsigned LANES = DATA_SIZE / BYTE_W;

    always_comb begin
        merged_o = old_i;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (be_i[i]) begin
                merged_o[i*BYTE_W +: BYTE_W] = wdata_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule : ram_bytelane_merge

// File: rtl/ram_dp_sync.sv
// Synchronous RAM with a read-only fetch port and a byte-enabled read/write data
// port; zero-fills itself after every reset before accepting any request.
module ram_dp_sync
    import ram_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned ADDRESS_SIZE = 16,
    parameter int unsigned DEPTH        = 65536
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        data_req,
    input  logic                        data_we,
    input  logic [DATA_SIZE/BYTE_W-1:0] data_be,
    input  logic [ADDRESS_SIZE-1:0]     data_addr,
    input  logic [DATA_SIZE-1:0]        data_wdata,
    output logic                        data_ready,
    output logic                        data_rvalid,
    output logic [DATA_SIZE-1:0]        data_rdata,
    output logic                        data_err,
    input  logic                        fetch_req,
    input  logic [ADDRESS_SIZE-1:0]     fetch_addr,
    output logic                        fetch_rvalid,
    output logic [DATA_SIZE-1:0]        fetch_rdata,
    output logic                        init_done
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_SIZE:0] DEPTH_L  = (ADDRESS_SIZE + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(DEPTH - 1);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];

    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;

    logic                 data_rvalid_q, data_err_q, fetch_rvalid_q;
    logic [DATA_SIZE-1:0] data_rdata_q, data_rdata_d;
    logic [DATA_SIZE-1:0] fetch_rdata_q, fetch_rdata_d;

    logic                 ready;
    logic                 data_acc, data_in_range, fetch_acc, fetch_in_range;
    logic [IDX_W-1:0]     data_idx, fetch_idx;
    logic [DATA_SIZE-1:0] data_old, merged;

    assign ready          = (state_q == ST_READY);
    assign data_acc       = data_req & ready;
    assign fetch_acc      = fetch_req & ready;
    assign data_in_range  = ({1'b0, data_addr} < DEPTH_L);
    assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_L);
    assign data_idx       = data_addr[IDX_W-1:0];
    assign fetch_idx      = fetch_addr[IDX_W-1:0];
    assign data_old       = data_in_range ? mem_q[data_idx] : '0;

    ram_bytelane_merge #(
        .DATA_SIZE (DATA_SIZE)
    ) u_merge (
        .old_i    (data_old),
        .wdata_i  (data_wdata),
        .be_i     (data_be),
        .merged_o (merged)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            if (cnt_q == LAST_IDX) begin
                state_d = ST_READY;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Read data registers hold their value unless a new read completes.
    always_comb begin
        data_rdata_d  = data_rdata_q;
        fetch_rdata_d = fetch_rdata_q;
        if (data_acc && !data_we) begin
            data_rdata_d = data_old;
        end
        if (fetch_acc) begin
            fetch_rdata_d = fetch_in_range ? mem_q[fetch_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_CLEAR;
            cnt_q          <= '0;
            data_rvalid_q  <= 1'b0;
            data_err_q     <= 1'b0;
            fetch_rvalid_q <= 1'b0;
            data_rdata_q   <= '0;
            fetch_rdata_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            data_rvalid_q  <= data_acc & ~data_we;
            data_err_q     <= data_acc & ~data_in_range;
            fetch_rvalid_q <= fetch_acc;
            data_rdata_q   <= data_rdata_d;
            fetch_rdata_q  <= fetch_rdata_d;
        end
    end

    // Storage has no reset; the clear sequencer zero-fills it instead.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (data_acc && data_we && data_in_range) begin
            mem_q[data_idx] <= merged;
        end
    end

    assign data_ready   = ready;
    assign init_done    = ready;
    assign data_rvalid  = data_rvalid_q;
    assign data_err     = data_err_q;
    assign data_rdata   = data_rdata_q;
    assign fetch_rvalid = fetch_rvalid_q;
    assign fetch_rdata  = fetch_rdata_q;

endmodule : ram_dp_sync

// File: tb/tb_ram_dp_sync.sv
// Directed bench for ram_dp_sync with DEPTH = 16: clear timing, byte-enable
// writes, read-first collision, out-of-range errors and mid-operation reset.
module tb_ram_dp_sync;

    logic        clk;
    logic        rst_n;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [15:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ready;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        init_done;

    int checks;
    int errors;

    ram_dp_sync #(
        .DEPTH (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_be      (data_be),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_ready   (data_ready),
        .data_rvalid  (data_rvalid),
        .data_rdata   (data_rdata),
        .data_err     (data_err),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_rvalid (fetch_rvalid),
        .fetch_rdata  (fetch_rdata),
        .init_done    (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (init_done !== 1'b1) begin
                check({tag, "_clear_rvalid"}, {30'd0, data_rvalid, fetch_rvalid}, 32'd0);
                check({tag, "_clear_err"}, {31'd0, data_err}, 32'd0);
            end
        end
        check({tag, "_init_cycles"}, n, 32'd16);
        check({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
    endtask

    task automatic dwrite(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic exp_err);
        data_req = 1'b1; data_we = 1'b1; data_addr = a; data_wdata = d; data_be = be;
        tick();
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
        check("wr_no_rvalid", {31'd0, data_rvalid}, 32'd0);
        check("wr_err", {31'd0, data_err}, {31'd0, exp_err});
    endtask

    task automatic dread(input string tag, input logic [15:0] a, input logic [31:0] exp,
                         input logic exp_err);
        data_req = 1'b1; data_we = 1'b0; data_addr = a; data_be = 4'hF;
        tick();
        data_req = 1'b0; data_be = 4'h0;
        check({tag, "_rvalid"}, {31'd0, data_rvalid}, 32'd1);
        check({tag, "_rdata"}, data_rdata, exp);
        check({tag, "_err"}, {31'd0, data_err}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] model [16];
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = '0; data_wdata = '0;
        fetch_req = 1'b0; fetch_addr = '0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        tick();
        tick();
        check("rst_outputs", {27'd0, data_ready, data_rvalid, data_err, fetch_rvalid, init_done}, 32'd0);
        check("rst_rdata", data_rdata, 32'd0);
        check("rst_fdata", fetch_rdata, 32'd0);

        // Requests held during clearing must be ignored.
        data_req = 1'b1; data_addr = 16'd2; fetch_req = 1'b1; fetch_addr = 16'd2;
        rst_n = 1'b1;
        wait_init("boot");
        data_req = 1'b0; fetch_req = 1'b0;

        for (int i = 0; i < 16; i++) begin
            fetch_req = 1'b1; fetch_addr = 16'(i);
            tick();
            check("fetch_zero_valid", {31'd0, fetch_rvalid}, 32'd1);
            check("fetch_zero_data", fetch_rdata, 32'd0);
        end
        fetch_req = 1'b0;
        tick();
        check("fetch_pulse_end", {31'd0, fetch_rvalid}, 32'd0);
        check("fetch_hold", fetch_rdata, 32'd0);

        dwrite(16'd5, 32'hDEADBEEF, 4'b1111, 1'b0);
        dread("rd5_full", 16'd5, 32'hDEADBEEF, 1'b0);
        tick();
        check("rd_pulse_end", {31'd0, data_rvalid}, 32'd0);
        check("rd_hold", data_rdata, 32'hDEADBEEF);

        dwrite(16'd5, 32'h000000AA, 4'b0001, 1'b0);
        dread("rd5_byte0", 16'd5, 32'hDEADBEAA, 1'b0);
        dwrite(16'd5, 32'h11223344, 4'b0000, 1'b0);
        dread("rd5_be0", 16'd5, 32'hDEADBEAA, 1'b0);
        dwrite(16'd6, 32'hA1B2C3D4, 4'b1010, 1'b0);
        dread("rd6_b31", 16'd6, 32'hA100C300, 1'b0);
        model[5] = 32'hDEADBEAA;
        model[6] = 32'hA100C300;

        // Write and fetch of address 3 in the same cycle: fetch sees the old word.
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'd3; data_wdata = 32'h12345678; data_be = 4'hF;
        fetch_req = 1'b1; fetch_addr = 16'd3;
        tick();
        data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
        check("coll_fetch_valid", {31'd0, fetch_rvalid}, 32'd1);
        check("coll_fetch_old", fetch_rdata, 32'h0);
        tick();
        fetch_req = 1'b0;
        check("coll_fetch_new", fetch_rdata, 32'h12345678);
        model[3] = 32'h12345678;
        dread("coll_read_new", 16'd3, 32'h12345678, 1'b0);

        // Fetch beyond DEPTH returns zero.
        fetch_req = 1'b1; fetch_addr = 16'd19;
        tick();
        fetch_req = 1'b0;
        check("fetch_oor_valid", {31'd0, fetch_rvalid}, 32'd1);
        check("fetch_oor_data", fetch_rdata, 32'h0);

        dread("oor_rd16", 16'd16, 32'h0, 1'b1);
        tick();
        check("oor_err_pulse_end", {31'd0, data_err}, 32'd0);
        dwrite(16'd20, 32'hFFFFFFFF, 4'hF, 1'b1);
        dwrite(16'd16, 32'hFFFFFFFF, 4'hF, 1'b1);
        for (int i = 0; i < 16; i++) begin
            dread("sweep", 16'(i), model[i], 1'b0);
        end

        // Asynchronous reset while a read result is being presented.
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'd5;
        tick();
        check("pre_rst_rvalid", {31'd0, data_rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        data_req = 1'b0;
        check("async_rst_flags", {27'd0, data_ready, data_rvalid, data_err, fetch_rvalid, init_done}, 32'd0);
        check("async_rst_rdata", data_rdata, 32'd0);
        check("async_rst_fdata", fetch_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        wait_init("rerst");
        dread("rerst_rd5", 16'd5, 32'h0, 1'b0);
        dread("rerst_rd3", 16'd3, 32'h0, 1'b0);
        dread("rerst_rd6", 16'd6, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram_dp_sync
